// File: rtl/fab_osc_tick_gen_if.sv
// fab_osc_tick_gen_if: valid/ready configuration port of the fabric tick generator
interface fab_osc_tick_gen_if #(
    parameter int CH_W  = 2,
    parameter int ACC_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_en;
    logic             cfg_err;
    modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_en, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_en, output cfg_ready, cfg_err);
endinterface

// File: rtl/fab_osc_tick_gen.sv
// fab_osc_tick_gen: start-up gated, runtime-programmable fractional-rate tick enables from one fabric clock
module fab_osc_tick_gen #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int ACC_W          = 24,
    parameter int STARTUP_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    fab_osc_tick_gen_if.slave cfg,
    output logic              clk_ready,
    output logic [NUM_CH-1:0] tick
);
    localparam logic [0:0] ST_STARTUP = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;
    localparam int CNT_W = $clog2(STARTUP_CYCLES) + 1;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             fire;
    logic             bad;
    logic [NUM_CH-1:0] en;
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W-1:0] acc [NUM_CH];
    assign fire          = cfg.cfg_valid && rdy;
    assign bad           = 32'(cfg.cfg_ch) >= NUM_CH;
    assign cfg.cfg_ready = rdy;
    assign clk_ready     = rdy;
    // oscillator start-up sequencer: count out STARTUP_CYCLES edges, then run until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STARTUP;
            cnt   <= '0;
        end else if (state == ST_STARTUP) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(STARTUP_CYCLES - 1)) state <= ST_RUN;
        end
    end
    // ready is a registered copy of the run state so it never depends on cfg_valid
    always_ff @(posedge clk) rdy <= rst ? 1'b0 : (state == ST_RUN);
    // one-cycle error pulse for an accepted request to a channel that does not exist
    always_ff @(posedge clk) cfg.cfg_err <= rst ? 1'b0 : (fire && bad);
    // per-channel phase accumulators; a config write restarts the channel and beats its carry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                inc[i]  <= '0;
                en[i]   <= 1'b0;
                acc[i]  <= '0;
                tick[i] <= 1'b0;
            end else if (fire && !bad && cfg.cfg_ch == CH_W'(i)) begin
                inc[i]  <= cfg.cfg_inc;
                en[i]   <= cfg.cfg_en;
                acc[i]  <= '0;
                tick[i] <= 1'b0;
            end else if (en[i] && state == ST_RUN) begin
                {tick[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, inc[i]};
            end else begin
                acc[i]  <= '0;
                tick[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fab_osc_tick_gen.sv
// tb_fab_osc_tick_gen: randomized scoreboard bench against an arithmetic tick-count model
module tb_fab_osc_tick_gen;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int ACC_W  = 8;
    localparam int SC     = 16;
    typedef struct packed {
        logic              rdy;
        logic              err;
        logic [NUM_CH-1:0] tick;
    } exp_t;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_ready;
    logic [NUM_CH-1:0] tick;
    exp_t              q[$];
    int                n_chk = 0;
    int                n_pass = 0;
    longint            k = 0;
    longint            c_m[NUM_CH];
    longint            inc_m[NUM_CH];
    bit                en_m[NUM_CH];
    fab_osc_tick_gen_if #(.CH_W(CH_W), .ACC_W(ACC_W)) cfg ();
    fab_osc_tick_gen #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ACC_W(ACC_W), .STARTUP_CYCLES(SC)) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfg),
        .clk_ready(clk_ready),
        .tick(tick)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask
    // reference model: channel i has produced floor(n*inc/2**ACC_W) ticks n edges after its configuration
    always @(posedge clk) begin : model
        exp_t e;
        bit   ok;
        int   ch;
        e = '0;
        if (rst) begin
            k = 0;
            for (int i = 0; i < NUM_CH; i++) en_m[i] = 1'b0;
        end else begin
            ok = cfg.cfg_valid && (k >= SC + 1);
            ch = int'(cfg.cfg_ch);
            k++;
            e.err = ok && (ch >= NUM_CH);
            if (ok && ch < NUM_CH) begin
                c_m[ch]   = k;
                inc_m[ch] = longint'(cfg.cfg_inc);
                en_m[ch]  = cfg.cfg_en;
            end
            e.rdy = (k >= SC + 1);
            for (int i = 0; i < NUM_CH; i++)
                e.tick[i] = en_m[i] && (k > c_m[i]) &&
                            ((((k - c_m[i]) * inc_m[i]) >> ACC_W) != (((k - c_m[i] - 1) * inc_m[i]) >> ACC_W));
        end
        q.push_back(e);
    end
    // monitor: compare every presented output cycle with the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("ready", 32'({clk_ready, cfg.cfg_ready}), 32'({2{e.rdy}}));
            check("cfg_err", 32'(cfg.cfg_err), 32'(e.err));
            check("tick", 32'(tick), 32'(e.tick));
        end
    end
    task automatic cfg_write(input int ch, input int inc, input bit en);
        int n = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = CH_W'(ch);
        cfg.cfg_inc   = ACC_W'(inc);
        cfg.cfg_en    = en;
        while (!cfg.cfg_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!cfg.cfg_ready) begin
            n_chk++;
            $display("FAIL handshake_timeout ready=0 required 1 at %0t", $time);
        end else begin
            @(posedge clk);
            #2;
        end
        cfg.cfg_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    initial begin
        int cnt3;
        int inc;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_inc   = '0;
        cfg.cfg_en    = 1'b0;
        idle(3);
        rst = 1'b0;
        cfg_write(0, 64, 1'b1);
        idle(20);
        cfg_write(1, 128, 1'b1);
        idle(1);
        cfg_write(1, 128, 1'b1);
        idle(10);
        cfg_write(5, 77, 1'b1);
        idle(10);
        cfg_write(3, 255, 1'b1);
        idle(10);
        cfg_write(2, 3, 1'b1);
        cnt3 = 0;
        @(posedge clk);
        repeat (2560) begin
            @(negedge clk);
            #1;
            if (tick[2]) cnt3++;
        end
        check("ch2_pulse_count", 32'(cnt3), 32'd30);
        #1;
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 3))
                0: inc = 0;
                1: inc = 255;
                2: inc = 1 << $urandom_range(0, 7);
                default: inc = int'($urandom_range(1, 254));
            endcase
            cfg_write(int'($urandom_range(0, 7)), inc, $urandom_range(0, 3) != 0);
            idle(int'($urandom_range(0, 40)));
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(30);
        cfg_write(0, 96, 1'b1);
        cfg_write(6, 1, 1'b1);
        idle(20);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
